// File: rtl/fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory request/response,
// redirect input and the prefetch-queue head towards decode.
interface fetch_unit_if #(
    parameter int ADDR_W  = 32,
    parameter int INSTR_W = 32,
    parameter int DEPTH   = 4
);
    localparam int CW = $clog2(DEPTH + 1);

    logic               imem_req;
    logic [ADDR_W-1:0]  imem_addr;
    logic               imem_ack;
    logic [INSTR_W-1:0] imem_rdata;
    logic               redirect;
    logic [ADDR_W-1:0]  redirect_pc;
    logic               ir_valid;
    logic [INSTR_W-1:0] ir;
    logic [ADDR_W-1:0]  ir_pc;
    logic               ir_ready;
    logic [CW-1:0]      count;

    modport master (
        output imem_req, imem_addr,
        input  imem_ack, imem_rdata,
        input  redirect, redirect_pc,
        output ir_valid, ir, ir_pc,
        input  ir_ready,
        output count
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_ack, imem_rdata,
        output redirect, redirect_pc,
        input  ir_valid, ir, ir_pc,
        output ir_ready,
        input  count
    );
endinterface

// File: rtl/fetch_unit.sv
// Stallable fetch stage: owns the PC, keeps one request in flight
// and buffers PC-tagged instructions in a circular prefetch queue.
module fetch_unit #(
    parameter int                ADDR_W   = 32,
    parameter int                INSTR_W  = 32,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                PC_STEP  = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    fetch_unit_if.master  bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] KILL = 2'd2;

    localparam logic [CW-1:0]     DEPTH_C = CW'(DEPTH);
    localparam logic [ADDR_W-1:0] STEP    = ADDR_W'(PC_STEP);

    logic [1:0]         state;
    logic [ADDR_W-1:0]  addr;
    logic [ADDR_W-1:0]  next_pc;
    logic [CW-1:0]      count;
    logic [CW-1:0]      count_next;
    logic [PW-1:0]      wptr;
    logic [PW-1:0]      rptr;
    logic               ack;
    logic               push;
    logic               pop;
    logic               room;

    logic [INSTR_W-1:0] q_ir [DEPTH];
    logic [ADDR_W-1:0]  q_pc [DEPTH];

    assign ack  = bus.imem_ack && (state != IDLE);
    assign push = ack && (state == BUSY) && !bus.redirect;
    assign pop  = (count != '0) && bus.ir_ready;

    assign count_next = count + CW'(push) - CW'(pop);
    // A new request is only issued when its data is sure to have a slot.
    assign room = count_next < DEPTH_C;

    assign bus.imem_req  = (state != IDLE);
    assign bus.imem_addr = addr;
    assign bus.count     = count;
    assign bus.ir_valid  = (count != '0);
    assign bus.ir        = q_ir[rptr];
    assign bus.ir_pc     = q_pc[rptr];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            addr    <= RESET_PC;
            next_pc <= RESET_PC;
            count   <= '0;
            wptr    <= '0;
            rptr    <= '0;
        end else if (bus.redirect) begin
            count   <= '0;
            wptr    <= '0;
            rptr    <= '0;
            next_pc <= bus.redirect_pc;
            // An unacked request must finish before the new target is issued.
            if (state == IDLE || ack) begin
                state <= BUSY;
                addr  <= bus.redirect_pc;
            end else begin
                state <= KILL;
            end
        end else begin
            count <= count_next;
            if (push) wptr <= wptr + PW'(1);
            if (pop)  rptr <= rptr + PW'(1);
            case (state)
                IDLE: begin
                    if (room) begin
                        state <= BUSY;
                        addr  <= next_pc;
                    end
                end
                BUSY: begin
                    if (ack) begin
                        next_pc <= addr + STEP;
                        if (room) addr  <= addr + STEP;
                        else      state <= IDLE;
                    end
                end
                KILL: begin
                    if (ack) begin
                        state <= BUSY;
                        addr  <= next_pc;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push && rst_n) begin
            q_ir[wptr] <= bus.imem_rdata;
            q_pc[wptr] <= addr;
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: memory model, scoreboard queue
// and a monitor that checks every decode handshake.
module tb_fetch_unit;
    logic clk;
    logic rst_n;

    fetch_unit_if #(.ADDR_W(32), .INSTR_W(32), .DEPTH(4)) b ();
    fetch_unit_if #(.ADDR_W(8), .INSTR_W(16), .DEPTH(2)) b8 ();

    fetch_unit #(
        .ADDR_W(32), .INSTR_W(32), .DEPTH(4),
        .RESET_PC(32'h0), .PC_STEP(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(b.master)
    );

    fetch_unit #(
        .ADDR_W(8), .INSTR_W(16), .DEPTH(2),
        .RESET_PC(8'hFE), .PC_STEP(1)
    ) dut8 (
        .clk(clk), .rst_n(rst_n), .bus(b8.master)
    );

    int vecs = 0;
    int errs = 0;
    int mem_lat = 0;

    logic [63:0] exp_q [$];
    logic [23:0] exp8 [$];

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_push(input logic [31:0] pc);
        exp_q.push_back({pc ^ 32'hA5A5_0000, pc});
    endtask

    task automatic wait_addr(input logic [31:0] a, input int lim);
        bit ok;
        ok = 0;
        for (int i = 0; i < lim; i++) begin
            cyc();
            if (b.imem_req && b.imem_addr == a) begin
                ok = 1;
                break;
            end
        end
        chk("wait_addr", 64'(ok), 64'd1);
    endtask

    task automatic wait_drain(input int lim);
        for (int i = 0; i < lim && exp_q.size() != 0; i++)
            @(negedge clk);
        @(negedge clk);
        chk("drain", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic do_reset(input int lat, input bit rdy);
        rst_n         = 0;
        b.redirect    = 0;
        b.redirect_pc = '0;
        b.ir_ready    = rdy;
        mem_lat       = lat;
        cyc();
        @(negedge clk);
        chk("rst_req", 64'(b.imem_req), 64'd0);
        chk("rst_addr", 64'(b.imem_addr), 64'd0);
        chk("rst_valid", 64'(b.ir_valid), 64'd0);
        chk("rst_count", 64'(b.count), 64'd0);
        exp_q.delete();
        cyc();
        rst_n = 1;
        @(negedge clk);
        chk("rel_req", 64'(b.imem_req), 64'd0);
    endtask

    // Main-DUT memory: ack after mem_lat wait cycles, and the request
    // must not move while it is still unacked.
    logic        p_req = 0;
    logic        p_ack = 0;
    logic [31:0] p_addr = '0;
    int          wcnt = 0;

    initial begin
        b.imem_ack   = 0;
        b.imem_rdata = '0;
        forever begin
            cyc();
            if (rst_n && p_req && !p_ack && b.imem_req)
                chk("addr_hold", 64'(b.imem_addr), 64'(p_addr));
            if (b.imem_req) begin
                if (wcnt >= mem_lat) begin
                    b.imem_ack   = 1;
                    b.imem_rdata = b.imem_addr ^ 32'hA5A5_0000;
                    wcnt = 0;
                end else begin
                    b.imem_ack = 0;
                    wcnt++;
                end
            end else begin
                b.imem_ack = 0;
                wcnt = 0;
            end
            p_req  = b.imem_req;
            p_ack  = b.imem_ack;
            p_addr = b.imem_addr;
        end
    end

    initial begin
        b8.imem_ack    = 0;
        b8.imem_rdata  = '0;
        b8.redirect    = 0;
        b8.redirect_pc = '0;
        b8.ir_ready    = 1;
        forever begin
            cyc();
            b8.imem_ack   = b8.imem_req;
            b8.imem_rdata = {8'hC3, b8.imem_addr};
        end
    end

    always @(negedge clk) begin
        if (rst_n && b.ir_valid && b.ir_ready && !b.redirect &&
            exp_q.size() != 0) begin
            logic [63:0] e;
            e = exp_q.pop_front();
            chk("ir_head", {b.ir, b.ir_pc}, e);
        end
    end

    always @(negedge clk) begin
        if (rst_n && b8.ir_valid && b8.ir_ready && exp8.size() != 0) begin
            logic [23:0] e;
            e = exp8.pop_front();
            chk("ir8_head", 64'({b8.ir, b8.ir_pc}), 64'(e));
        end
    end

    initial begin
        exp8.push_back({16'hC3FE, 8'hFE});
        exp8.push_back({16'hC3FF, 8'hFF});
        exp8.push_back({16'hC300, 8'h00});
        exp8.push_back({16'hC301, 8'h01});

        // zero-wait streaming
        do_reset(0, 1);
        for (int k = 0; k < 8; k++) exp_push(32'(k));
        for (int k = 0; k < 8; k++) begin
            cyc();
            @(negedge clk);
            chk("stream_req", 64'(b.imem_req), 64'd1);
            chk("stream_addr", 64'(b.imem_addr), 64'(k));
        end
        wait_drain(10);

        // fill while stalled, then drain
        do_reset(0, 0);
        for (int k = 0; k < 5; k++) exp_push(32'(k));
        repeat (6) cyc();
        @(negedge clk);
        chk("full_count", 64'(b.count), 64'd4);
        chk("full_req", 64'(b.imem_req), 64'd0);
        chk("full_pc", 64'(b.ir_pc), 64'd0);
        cyc();
        b.ir_ready = 1;
        cyc();
        @(negedge clk);
        chk("resume_count", 64'(b.count), 64'd3);
        chk("resume_req", 64'(b.imem_req), 64'd1);
        chk("resume_addr", 64'(b.imem_addr), 64'd4);
        wait_drain(10);

        // redirect while addr 2 is outstanding
        do_reset(2, 0);
        wait_addr(32'd2, 20);
        b.redirect    = 1;
        b.redirect_pc = 32'h40;
        @(negedge clk);
        chk("kill_pre_count", 64'(b.count), 64'd2);
        exp_push(32'h40);
        exp_push(32'h41);
        cyc();
        b.redirect = 0;
        b.ir_ready = 1;
        @(negedge clk);
        chk("kill_count", 64'(b.count), 64'd0);
        chk("kill_req", 64'(b.imem_req), 64'd1);
        chk("kill_addr", 64'(b.imem_addr), 64'd2);
        cyc();
        @(negedge clk);
        chk("kill_hold", 64'(b.imem_addr), 64'd2);
        cyc();
        @(negedge clk);
        chk("kill_new_req", 64'(b.imem_req), 64'd1);
        chk("kill_new_addr", 64'(b.imem_addr), 64'h40);
        wait_drain(30);

        // redirect coinciding with ack of addr 5 and a pop
        do_reset(0, 1);
        for (int k = 0; k < 4; k++) exp_push(32'(k));
        exp_push(32'h80);
        exp_push(32'h81);
        exp_push(32'h82);
        wait_addr(32'd5, 20);
        b.redirect    = 1;
        b.redirect_pc = 32'h80;
        @(negedge clk);
        chk("ackred_pre_count", 64'(b.count), 64'd1);
        cyc();
        b.redirect = 0;
        @(negedge clk);
        chk("ackred_count", 64'(b.count), 64'd0);
        chk("ackred_req", 64'(b.imem_req), 64'd1);
        chk("ackred_addr", 64'(b.imem_addr), 64'h80);
        cyc();
        @(negedge clk);
        chk("ackred_addr2", 64'(b.imem_addr), 64'h81);
        wait_drain(10);

        // reset during an acked fetch with three entries queued
        do_reset(2, 0);
        begin
            bit ok;
            ok = 0;
            for (int i = 0; i < 30; i++) begin
                cyc();
                if (b.count == 3) begin
                    ok = 1;
                    break;
                end
            end
            chk("wait_count3", 64'(ok), 64'd1);
            ok = 0;
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                if (b.imem_ack) begin
                    ok = 1;
                    break;
                end
            end
            chk("wait_ack", 64'(ok), 64'd1);
        end
        chk("mid_count", 64'(b.count), 64'd3);
        chk("mid_req", 64'(b.imem_req), 64'd1);
        rst_n = 0;
        @(posedge clk);
        #1;
        rst_n = 1;
        @(negedge clk);
        chk("mid_rst_valid", 64'(b.ir_valid), 64'd0);
        chk("mid_rst_count", 64'(b.count), 64'd0);
        chk("mid_rst_req", 64'(b.imem_req), 64'd0);
        chk("mid_rst_addr", 64'(b.imem_addr), 64'd0);
        exp_q.delete();
        exp_push(32'd0);
        exp_push(32'd1);
        b.ir_ready = 1;
        cyc();
        @(negedge clk);
        chk("restart_req", 64'(b.imem_req), 64'd1);
        chk("restart_addr", 64'(b.imem_addr), 64'd0);
        wait_drain(20);

        chk("drain8", 64'(exp8.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Parametrised instruction-fetch front end for the next CPU generation. Replaces the free-running PC increment with a handshaked, stallable fetch stage.
- Owns the PC and issues word-addressed requests to a variable-latency instruction memory.
- Buffers returned instructions, tagged with their PC, in a DEPTH-entry prefetch queue that feeds decode over a valid/ready handshake.
- Accepts branch/jump redirects, which flush the queue and squash any in-flight fetch.

Parameters:
ADDR_W, 32, PC/address width; PC arithmetic is modulo 2^ADDR_W
INSTR_W, 32, instruction width
DEPTH, 4, prefetch queue entries; power of 2, >= 2
RESET_PC, 0, PC loaded on reset
PC_STEP, 1, PC increment per instruction (word addressing)

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  synchronous active-low reset
imem_req  out  1  fetch request to instruction memory
imem_addr  out  ADDR_W  fetch address; stable while imem_req=1 and not acked
imem_ack  in  1  memory response valid; ignored unless imem_req=1
imem_rdata  in  INSTR_W  instruction data, valid with imem_ack
redirect  in  1  flush and restart fetch at redirect_pc
redirect_pc  in  ADDR_W  redirect target
ir_valid  out  1  queue head valid
ir  out  INSTR_W  queue head instruction
ir_pc  out  ADDR_W  PC of queue head
ir_ready  in  1  decode consumes head when ir_valid=1 and ir_ready=1
count  out  $clog2(DEPTH+1)  current queue occupancy

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - state=IDLE, count=0, pointers=0.
  - imem_req=0, imem_addr=RESET_PC, next_pc=RESET_PC, ir_valid=0.
  - Reset overrides redirect, ack and pop in the same cycle.
  - Reset mid-operation discards queue contents and any outstanding fetch.
- Memory protocol:
  - At most one outstanding request.
  - Once imem_req rises, it and imem_addr stay constant until a cycle with imem_ack=1.
  - An ack in the first req cycle is legal (zero-wait).
- State machine (imem_req = state!=IDLE; all outputs registered except ir/ir_pc/ir_valid):
  - IDLE: no request outstanding.
    - If count_next < DEPTH: go to BUSY and set imem_addr=next_pc.
  - BUSY: request outstanding and live.
    - On ack without redirect: push {imem_rdata, imem_addr}; next_pc=imem_addr+PC_STEP.
    - Then go to BUSY with imem_addr=imem_addr+PC_STEP if count_next < DEPTH, else IDLE.
    - Zero-wait memory with ir_ready=1 therefore sustains 1 instruction/cycle.
  - KILL: request outstanding but squashed.
    - imem_addr holds its old value.
    - On ack: data dropped; go to BUSY with imem_addr=next_pc.
- count_next = count + push - pop, evaluated in the same cycle.
- The slot-reservation rule above guarantees a push never occurs while full.
- Redirect (highest priority after reset):
  - count and pointers go to 0; any same-cycle pop or push is discarded; next_pc=redirect_pc.
  - From IDLE: go to BUSY with imem_addr=redirect_pc.
  - From BUSY without ack: go to KILL.
  - From BUSY with ack: data dropped; go to BUSY with imem_addr=redirect_pc.
  - From KILL without ack: stay in KILL; latest target wins.
  - From KILL with ack: go to BUSY with imem_addr=redirect_pc.
- Queue:
  - Circular buffer; read/write pointers wrap modulo DEPTH.
  - ir_valid = (count != 0); ir and ir_pc are the head entry, combinational from storage.
  - Push and pop in the same cycle leave count unchanged.
  - Pop when empty has no effect.
- Ordering: ir_pc sequence equals the issued address sequence, excluding squashed fetches.
- Latency: first imem_req in the 2nd cycle after reset release; data acked in cycle N is visible on ir at cycle N+1.

Test Plan:
1. Reset, then zero-wait memory (imem_ack=1, rdata=addr^32'hA5A5_0000), ir_ready=1 -> imem_addr 0,1,2,... on consecutive cycles; ir_pc 0,1,2,... one per cycle; ir matches its rdata.
2. ir_ready=0, DEPTH=4 -> pcs 0-3 enqueued, count=4, imem_req=0. Then ir_ready=1 -> pcs 0,1,2,3 drained in order; a request for addr 4 is issued.
3. 3-cycle memory latency; redirect with redirect_pc=0x40 while addr 2 is unacked -> count=0 next cycle; req held at addr 2 until ack; that data never appears; next request is addr 0x40; first ir_pc=0x40.
4. Redirect to 0x80 in the same cycle as the ack for addr 5, with a simultaneous pop -> nothing from addr 5 is enqueued; count=0; next imem_addr=0x80 with no idle cycle.
5. ADDR_W=8, RESET_PC=8'hFE, PC_STEP=1 -> ir_pc sequence FE, FF, 00, 01 (wrap).
6. count=3 with a request outstanding; rst_n=0 for one cycle while imem_ack=1 -> ir_valid=0, count=0, imem_req=0, imem_addr=RESET_PC; the acked data is not enqueued; fetching restarts at RESET_PC.
